submod_responder: RTL and testbench
===================================

Name: submod_responder

Overview:
- Child-side responder for parent-to-submodule command traffic. The parent issues one command at a time; this block executes it against an internal WIDTH-bit register and returns the result.
- Sits below a parent module as an instantiated submodule. It is the servicing end of the parent→child request path: the parent initiates, this block answers.
- Multi-cycle: accept, busy countdown, then hold the response until the parent takes it.

Parameters:
- WIDTH, 8, width of the internal register and of the data buses.
- LATENCY, 2, busy cycles between acceptance and response; legal range 1..15.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  parent presents a command.
- req_ready  output  1  block can accept a command.
- req_op  input  3  opcode.
- req_data  input  WIDTH  operand for ADD and LOAD.
- resp_valid  output  1  response available.
- resp_ready  input  1  parent consumes the response.
- resp_data  output  WIDTH  register value after the command.
- resp_err  output  1  illegal-opcode flag (see Optional Feature).
- busy  output  1  high while in the BUSY state.

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, register=0, countdown=0, latched op/data=0.
  - req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0.
- Opcodes:
  - 000 READ: no change.
  - 001 INC: reg+1.
  - 010 ADD: reg+req_data.
  - 011 LOAD: reg=req_data.
  - 100 CLEAR: reg=0.
  - 101–111: illegal.
- Arithmetic: modulo 2^WIDTH. INC of 0xFF gives 0x00; ADD 0xF0+0x20 gives 0x10. No carry is reported.
- State machine: IDLE → BUSY → RESP → IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge N: latch op and data, load countdown=LATENCY, go to BUSY.
- BUSY:
  - req_ready=0, busy=1. Countdown decrements each cycle.
  - When countdown reaches 1: apply the op to the register on that edge, drive resp_data with the new value, go to RESP.
  - Net timing: resp_valid first high in cycle N+LATENCY+1; the register updates at that same edge.
- RESP:
  - resp_valid=1. resp_data and resp_err are held stable while resp_ready=0.
  - On resp_valid && resp_ready: go to IDLE and drop resp_valid next cycle.
- Throughput: one command per LATENCY+2 cycles minimum. No command overlap.
  - req_ready returns high the cycle after the handshake.
  - A req_valid held through BUSY/RESP is not accepted until IDLE.
- Request stability: req_op and req_data are sampled only at the accepting edge; later changes are ignored.
- resp_ready outside RESP is ignored.
- Reset in any state takes effect at the next edge and overrides all other inputs:
  - any in-flight command is dropped and the register is not updated;
  - resp_valid goes low.
- Register state persists across commands; no command touches it except through the opcode effects above.

Optional Feature:
- Macro: SUBMOD_RESPONDER_ERR_EN.
- Defined: an illegal opcode (101–111) leaves the register unchanged and sets resp_err=1 with resp_data=current register. resp_err is cleared on the next acceptance or on reset. Legal opcodes give resp_err=0.
- Undefined: illegal opcodes behave exactly as READ, and resp_err is constant 0. Port list is identical in both builds.

Test Plan:
- Reset, then LOAD 0x5A accepted at cycle 0 (LATENCY=2) -> busy=1 in cycles 1–2, resp_valid=1 and resp_data=0x5A at cycle 3, req_ready=0 in cycles 1–3.
- LOAD 0xFF, then INC -> resp_data=0x00; then ADD 0x20 after LOAD 0xF0 -> resp_data=0x10 (wrap).
- Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 and a changing req_op -> resp_data/resp_valid stable; no new acceptance until one cycle after the resp_ready handshake.
- Assert reset during BUSY after LOAD 0x33 issued over register 0x11 -> next cycle IDLE, resp_valid=0, register=0; a subsequent READ returns 0x00.
- Opcode 110 with register 0x42: macro defined -> resp_err=1, resp_data=0x42; macro undefined -> resp_err=0, resp_data=0x42.
- Back-to-back INC x3 from 0 with resp_ready tied 1 -> responses 0x01, 0x02, 0x03, spaced LATENCY+2 cycles apart.

Source files
------------

// File: rtl/submod_responder_if.sv
// Purpose : parent<->submodule command/response bundle for submod_responder.
// Latency : n/a (wires only).
// Backpressure: req_valid/req_ready for commands, resp_valid/resp_ready for results.
//
// Signals:
//   req_valid  parent -> child   command present
//   req_ready  child  -> parent  child can take a command
//   req_op     parent -> child   3-bit opcode
//   req_data   parent -> child   WIDTH-bit operand
//   resp_valid child  -> parent  result present
//   resp_ready parent -> child   parent takes the result
//   resp_data  child  -> parent  register value after the command
//   resp_err   child  -> parent  illegal-opcode flag
//   busy       child  -> parent  command executing
interface submod_responder_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_data;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_err;
   logic             busy;

   // Parent side: issues commands, consumes responses.
   modport master (
      output req_valid,
      output req_op,
      output req_data,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_data,
      input  resp_err,
      input  busy
   );

   // Child side: accepts commands, produces responses.
   modport slave (
      input  req_valid,
      input  req_op,
      input  req_data,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_data,
      output resp_err,
      output busy
   );
endinterface

// File: rtl/submod_responder.sv
// Purpose : child-side responder; executes one parent command against an internal WIDTH-bit register.
// Latency : response valid LATENCY+1 cycles after the accepting edge; one command per LATENCY+2 cycles at best.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-high; overrides everything, drops any in-flight command
//   bus    submod_responder_if.slave (request/response handshakes, busy)
//
// Opcodes: 000 READ, 001 INC, 010 ADD, 011 LOAD, 100 CLEAR, 101-111 illegal.
// Arithmetic wraps modulo 2^WIDTH; no carry is reported.
//
// Build option: define SUBMOD_RESPONDER_ERR_EN to flag illegal opcodes on resp_err.
// Without it illegal opcodes act as READ and resp_err is tied low.
module submod_responder #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 2   // legal range 1..15 (fits the 4-bit countdown)
) (
   input  logic             clock,
   input  logic             reset,
   submod_responder_if.slave bus
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [2:0] OP_READ  = 3'b000;
   localparam logic [2:0] OP_INC   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100;

   localparam logic [3:0]       LAT_INIT = 4'(LATENCY);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_q,     state_d;
   logic [WIDTH-1:0] reg_q,       reg_d;
   logic [3:0]       cnt_q,       cnt_d;
   logic [2:0]       op_q,        op_d;
   logic [WIDTH-1:0] data_q,      data_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;

   logic             accept;     // request handshake this cycle
   logic             apply;      // last busy cycle: register updates on this edge
   logic [WIDTH-1:0] new_val;    // register value the latched command produces

   assign accept = (state_q == ST_IDLE) && bus.req_valid;
   assign apply  = (state_q == ST_BUSY) && (cnt_q == 4'd1);

   // ------------------------------------------------------------------
   // Datapath: result of the latched command. Illegal opcodes fall
   // through to the default arm and leave the register unchanged,
   // which is READ behaviour in both builds.
   // ------------------------------------------------------------------
   always_comb begin
      new_val = reg_q;
      case (op_q)
         OP_READ:  new_val = reg_q;
         OP_INC:   new_val = reg_q + ONE;
         OP_ADD:   new_val = reg_q + data_q;
         OP_LOAD:  new_val = data_q;
         OP_CLEAR: new_val = '0;
         default:  new_val = reg_q;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM next-state and datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      reg_d       = reg_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      data_d      = data_q;
      resp_data_d = resp_data_q;

      case (state_q)
         ST_IDLE: begin
            // Operands are captured only here; later changes on the
            // request bus have no effect on this command.
            if (accept) begin
               op_d    = bus.req_op;
               data_d  = bus.req_data;
               cnt_d   = LAT_INIT;
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (apply) begin
               reg_d       = new_val;
               resp_data_d = new_val;
               state_d     = ST_RESP;
            end
         end

         ST_RESP: begin
            // resp_data is held by simply not reloading it here.
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         reg_q       <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         data_q      <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         reg_q       <= reg_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         data_q      <= data_d;
         resp_data_q <= resp_data_d;
      end
   end

   // ------------------------------------------------------------------
   // Error flag
   // ------------------------------------------------------------------
`ifdef SUBMOD_RESPONDER_ERR_EN
   logic resp_err_q, resp_err_d;
   logic illegal_op;

   assign illegal_op = (op_q == 3'b101) || (op_q == 3'b110) || (op_q == 3'b111);

   // Flag is set with the response and survives until the next command
   // is accepted, so the parent can still read it after the handshake.
   always_comb begin
      resp_err_d = resp_err_q;
      if (accept) begin
         resp_err_d = 1'b0;
      end else if (apply) begin
         resp_err_d = illegal_op;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         resp_err_q <= 1'b0;
      end else begin
         resp_err_q <= resp_err_d;
      end
   end

   assign bus.resp_err = resp_err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs: all decoded from registered state, no input-to-output paths
   // ------------------------------------------------------------------
   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.busy       = (state_q == ST_BUSY);
   assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_submod_responder.sv
// Purpose : directed self-checking bench for submod_responder (WIDTH=8, LATENCY=2).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: exercises held responses, held requests and back-to-back commands.
module tb_submod_responder;

   localparam int WIDTH   = 8;
   localparam int LATENCY = 2;

   localparam logic [2:0] OP_READ  = 3'b000;
   localparam logic [2:0] OP_INC   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100;

`ifdef SUBMOD_RESPONDER_ERR_EN
   localparam logic EXP_ILLEGAL_ERR = 1'b1;
`else
   localparam logic EXP_ILLEGAL_ERR = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_cmp  = 0;
   int n_fail = 0;

   submod_responder_if #(.WIDTH(WIDTH)) bus ();

   submod_responder #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Hard stop in case a broken design wedges the sequence.
   initial begin
      #100000;
      $display("FAIL watchdog: observed no completion expected completion before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command from IDLE, wait for the response, take it.
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                         output logic [7:0] rd, output logic re);
      int n;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = d;
      step();
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         step();
         n++;
      end
      check("cmd_resp_seen", 32'(bus.resp_valid), 32'd1);
      rd = bus.resp_data;
      re = bus.resp_err;
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic       re;
      logic [7:0] b2b_dat [3];
      int         b2b_cyc [3];
      int         got;
      int         t;

      bus.req_valid  = 1'b0;
      bus.req_op     = OP_READ;
      bus.req_data   = '0;
      bus.resp_ready = 1'b0;

      // ---------------- reset state ----------------
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst_req_ready",  32'(bus.req_ready),  32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_data",  32'(bus.resp_data),  32'h00);
      check("rst_resp_err",   32'(bus.resp_err),   32'd0);
      check("rst_busy",       32'(bus.busy),       32'd0);

      // ---------------- LOAD 0x5A cycle-accurate ----------------
      // cycle 0: request presented, accepted at the end of this cycle
      bus.req_valid = 1'b1;
      bus.req_op    = OP_LOAD;
      bus.req_data  = 8'h5A;
      step();                          // cycle 1
      bus.req_valid = 1'b0;
      check("c1_busy",      32'(bus.busy),       32'd1);
      check("c1_req_ready", 32'(bus.req_ready),  32'd0);
      check("c1_resp_vld",  32'(bus.resp_valid), 32'd0);
      step();                          // cycle 2
      check("c2_busy",      32'(bus.busy),       32'd1);
      check("c2_req_ready", 32'(bus.req_ready),  32'd0);
      check("c2_resp_vld",  32'(bus.resp_valid), 32'd0);
      step();                          // cycle 3
      check("c3_resp_vld",  32'(bus.resp_valid), 32'd1);
      check("c3_resp_data", 32'(bus.resp_data),  32'h5A);
      check("c3_req_ready", 32'(bus.req_ready),  32'd0);
      check("c3_busy",      32'(bus.busy),       32'd0);
      bus.resp_ready = 1'b1;
      step();                          // cycle 4
      bus.resp_ready = 1'b0;
      check("c4_resp_vld",  32'(bus.resp_valid), 32'd0);
      check("c4_req_ready", 32'(bus.req_ready),  32'd1);

      // ---------------- arithmetic wrap ----------------
      do_cmd(OP_LOAD, 8'hFF, rd, re);
      check("load_ff",   32'(rd), 32'hFF);
      do_cmd(OP_INC, 8'h00, rd, re);
      check("inc_wrap",  32'(rd), 32'h00);
      do_cmd(OP_LOAD, 8'hF0, rd, re);
      check("load_f0",   32'(rd), 32'hF0);
      do_cmd(OP_ADD, 8'h20, rd, re);
      check("add_wrap",  32'(rd), 32'h10);
      do_cmd(OP_READ, 8'hAA, rd, re);
      check("read_keep", 32'(rd), 32'h10);
      do_cmd(OP_CLEAR, 8'h55, rd, re);
      check("clear",     32'(rd), 32'h00);

      // ---------------- held response, held request ----------------
      do_cmd(OP_LOAD, 8'h77, rd, re);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_ADD;
      bus.req_data  = 8'h01;
      step();
      bus.req_valid = 1'b0;
      step();
      step();                          // now in RESP
      for (int i = 0; i < 5; i++) begin
         check("hold_resp_vld",  32'(bus.resp_valid), 32'd1);
         check("hold_resp_data", 32'(bus.resp_data),  32'h78);
         check("hold_req_ready", 32'(bus.req_ready),  32'd0);
         bus.req_valid = 1'b1;
         bus.req_op    = 3'(i + 3);
         bus.req_data  = 8'(8'hA0 + i);
         step();
      end
      // Take the response while a new INC is already waiting.
      check("hold_end_vld", 32'(bus.resp_valid), 32'd1);
      bus.req_op     = OP_INC;
      bus.req_data   = 8'h00;
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      check("post_hs_resp_vld",  32'(bus.resp_valid), 32'd0);
      check("post_hs_req_ready", 32'(bus.req_ready),  32'd1);
      check("post_hs_busy",      32'(bus.busy),       32'd0);
      step();
      // Changes after acceptance must not affect the command.
      bus.req_valid = 1'b0;
      bus.req_op    = OP_LOAD;
      bus.req_data  = 8'hEE;
      check("held_req_accepted", 32'(bus.busy), 32'd1);
      step();
      step();
      check("held_inc_vld",  32'(bus.resp_valid), 32'd1);
      check("held_inc_data", 32'(bus.resp_data),  32'h79);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;

      // ---------------- reset during BUSY ----------------
      do_cmd(OP_LOAD, 8'h11, rd, re);
      check("load_11", 32'(rd), 32'h11);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_LOAD;
      bus.req_data  = 8'h33;
      step();
      bus.req_valid = 1'b0;
      check("rb_busy_before", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rb_resp_vld",  32'(bus.resp_valid), 32'd0);
      check("rb_req_ready", 32'(bus.req_ready),  32'd1);
      check("rb_busy",      32'(bus.busy),       32'd0);
      check("rb_resp_data", 32'(bus.resp_data),  32'h00);
      step();
      step();
      step();
      check("rb_no_stale_resp", 32'(bus.resp_valid), 32'd0);
      do_cmd(OP_READ, 8'h00, rd, re);
      check("rb_read_zero", 32'(rd), 32'h00);

      // ---------------- illegal opcode ----------------
      do_cmd(OP_LOAD, 8'h42, rd, re);
      check("load_42",     32'(rd), 32'h42);
      check("load_42_err", 32'(re), 32'd0);
      do_cmd(3'b110, 8'h99, rd, re);
      check("illegal_data", 32'(rd), 32'h42);
      check("illegal_err",  32'(re), 32'(EXP_ILLEGAL_ERR));
      check("illegal_err_held", 32'(bus.resp_err), 32'(EXP_ILLEGAL_ERR));
      do_cmd(OP_READ, 8'h00, rd, re);
      check("legal_after_data", 32'(rd), 32'h42);
      check("legal_after_err",  32'(re), 32'd0);

      // ---------------- back-to-back INC x3 ----------------
      do_cmd(OP_CLEAR, 8'h00, rd, re);
      check("b2b_clear", 32'(rd), 32'h00);
      for (int i = 0; i < 3; i++) begin
         b2b_dat[i] = 8'h00;
         b2b_cyc[i] = 0;
      end
      bus.req_valid  = 1'b1;
      bus.req_op     = OP_INC;
      bus.req_data   = 8'h00;
      bus.resp_ready = 1'b1;
      got = 0;
      t   = 0;
      while (got < 3 && t < 40) begin
         step();
         t++;
         if (bus.resp_valid) begin
            b2b_dat[got] = bus.resp_data;
            b2b_cyc[got] = t;
            got++;
            if (got == 3) bus.req_valid = 1'b0;
         end
      end
      step();
      bus.resp_ready = 1'b0;
      check("b2b_count",  32'(got),        32'd3);
      check("b2b_dat0",   32'(b2b_dat[0]), 32'h01);
      check("b2b_dat1",   32'(b2b_dat[1]), 32'h02);
      check("b2b_dat2",   32'(b2b_dat[2]), 32'h03);
      check("b2b_first",  32'(b2b_cyc[0]), 32'(LATENCY + 1));
      check("b2b_space1", 32'(b2b_cyc[1] - b2b_cyc[0]), 32'(LATENCY + 2));
      check("b2b_space2", 32'(b2b_cyc[2] - b2b_cyc[1]), 32'(LATENCY + 2));
      check("b2b_idle",   32'(bus.req_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
